// File: rtl/approx_mult_seq_pkg.sv
// approx_mult_pkg: shared types and helpers for the sequential approximate multiplier.
//   mode_t  : per-operation arithmetic mode (exact / truncate / truncate+compensate / reserved)
//   state_t : control FSM states
//   col_mask: keeps partial-product columns K and above, clears columns 0..K-1
package approx_mult_pkg;

   // Widest product the mask helper supports (2W <= MAX_PW).
   localparam int MAX_PW = 128;

   typedef enum logic [1:0] {
      MODE_EXACT      = 2'b00,
      MODE_TRUNC      = 2'b01,
      MODE_TRUNC_COMP = 2'b10,
      MODE_RSVD       = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // ~((1<<k)-1); callers size-cast the result down to their 2W product width.
   function automatic logic [MAX_PW-1:0] col_mask(input int k);
      return ~((MAX_PW'(1) << k) - MAX_PW'(1));
   endfunction

endpackage

// File: rtl/approx_mult_seq_if.sv
// approx_mult_seq_if: operand and result valid/ready channels of approx_mult_seq.
//   in_valid/in_ready/in_a/in_b/in_mode : operation request channel
//   out_valid/out_ready/out_res/out_mode: product result channel
//   master: stream source + sink side; slave: the multiplier.
interface approx_mult_seq_if #(
   parameter int W = 16
);
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic [1:0]     in_mode;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] out_res;
   logic [1:0]     out_mode;

   modport master (
      output in_valid, in_a, in_b, in_mode, out_ready,
      input  in_ready, out_valid, out_res, out_mode
   );

   modport slave (
      input  in_valid, in_a, in_b, in_mode, out_ready,
      output in_ready, out_valid, out_res, out_mode
   );
endinterface

// File: rtl/approx_mult_seq_pp_row.sv
// approx_pp_row: combinational sum of the BPC partial products handled in one cycle.
//   a_sh_i   : multiplicand already shifted left by offset_i (2W bits)
//   b_bits_i : the BPC multiplier bits for this cycle
//   offset_i : bit position of b_bits_i[0] within the original multiplier
//   mode_i   : arithmetic mode; truncating modes clear columns below K
//   sum_o    : masked sum of the partial products (2W bits)
module approx_pp_row
   import approx_mult_pkg::*;
#(
   parameter int W   = 16,
   parameter int BPC = 1,
   parameter int K   = 8
) (
   input  logic [2*W-1:0]      a_sh_i,
   input  logic [BPC-1:0]      b_bits_i,
   input  logic [$clog2(W):0]  offset_i,
   input  mode_t               mode_i,
   output logic [2*W-1:0]      sum_o
);
   localparam int PW = 2 * W;
   localparam logic [PW-1:0] MASK = PW'(col_mask(K));

   logic          trunc;
   logic [PW-1:0] pp;

   always_comb begin
      // Once the row sits at or above column K every bit is kept, so the mask is skipped.
      trunc = ((mode_i == MODE_TRUNC) || (mode_i == MODE_TRUNC_COMP)) && (int'(offset_i) < K);
      sum_o = '0;
      pp    = '0;
      for (int j = 0; j < BPC; j++) begin
         pp = b_bits_i[j] ? (a_sh_i << j) : '0;
         if (trunc) pp = pp & MASK;
         sum_o = sum_o + pp;
      end
   end
endmodule

// File: rtl/approx_mult_seq.sv
// approx_mult_seq: multi-cycle shift-add unsigned multiplier with exact, truncated
// and truncated+compensated modes; BPC multiplier bits are consumed per cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : approx_mult_seq_if.slave (operand channel in, product channel out)
module approx_mult_seq
   import approx_mult_pkg::*;
#(
   parameter int W   = 16,
   parameter int BPC = 1,
   parameter int K   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   approx_mult_seq_if.slave  bus
);
   localparam int PW  = 2 * W;
   localparam int CYC = W / BPC;
   localparam int CW  = $clog2(CYC + 1);
   localparam int OW  = $clog2(W) + 1;
   localparam logic [PW-1:0] COMP = (K > 0) ? (PW'(1) << ((K > 0) ? K - 1 : 0)) : '0;

   state_t        state_q, state_d;
   mode_t         mode_q, mode_d;
   logic [PW-1:0] a_q, a_d;
   logic [PW-1:0] acc_q, acc_d;
   logic [W-1:0]  b_q, b_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [OW-1:0] off_q, off_d;
   logic          in_ready_q, in_ready_d;
   logic [PW-1:0] pp_sum;

   approx_pp_row #(.W(W), .BPC(BPC), .K(K)) u_pp_row (
      .a_sh_i   (a_q),
      .b_bits_i (b_q[BPC-1:0]),
      .offset_i (off_q),
      .mode_i   (mode_q),
      .sum_o    (pp_sum)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      a_d     = a_q;
      acc_d   = acc_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      off_d   = off_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               a_d     = {{W{1'b0}}, bus.in_a};
               b_d     = bus.in_b;
               mode_d  = (bus.in_mode == MODE_RSVD) ? MODE_EXACT : mode_t'(bus.in_mode);
               acc_d   = '0;
               cnt_d   = CW'(CYC);
               off_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            acc_d = acc_q + pp_sum;
            a_d   = a_q << BPC;
            b_d   = b_q >> BPC;
            off_d = off_q + OW'(BPC);
            cnt_d = cnt_q - CW'(1);
            if (cnt_d == '0) begin
               // Compensation lands on the final accumulate so DONE holds the finished value.
               if (mode_q == MODE_TRUNC_COMP) acc_d = acc_d + COMP;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Registered ready: low through reset, high from the first edge spent in IDLE.
      in_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_EXACT;
         a_q        <= '0;
         acc_q      <= '0;
         b_q        <= '0;
         cnt_q      <= '0;
         off_q      <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         a_q        <= a_d;
         acc_q      <= acc_d;
         b_q        <= b_d;
         cnt_q      <= cnt_d;
         off_q      <= off_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Result and mode are only exposed in DONE, so a partial accumulator is never visible.
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.out_res   = (state_q == ST_DONE) ? acc_q : '0;
   assign bus.out_mode  = (state_q == ST_DONE) ? mode_q : MODE_EXACT;
endmodule

// File: tb/tb_approx_mult_seq.sv
module tb_approx_mult_seq;
   import approx_mult_pkg::*;

   localparam int W = 16;
   localparam int K = 8;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  m;
      logic [31:0] res;
      logic [1:0]  mode;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   approx_mult_seq_if #(.W(W)) bus  ();
   approx_mult_seq_if #(.W(W)) bus2 ();
   approx_mult_seq_if #(.W(W)) bus4 ();

   approx_mult_seq #(.W(W), .BPC(1), .K(K)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   approx_mult_seq #(.W(W), .BPC(2), .K(K)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   approx_mult_seq #(.W(W), .BPC(4), .K(K)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   exp_t sb[$];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   rand_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] m);
      logic [31:0] mask;
      logic [31:0] s;
      mask = (m == 2'b01 || m == 2'b10) ? ~((32'd1 << K) - 32'd1) : '1;
      s = '0;
      for (int i = 0; i < W; i++)
         if (b[i]) s = s + ((32'(a) << i) & mask);
      if (m == 2'b10 && K > 0) s = s + (32'd1 << (K - 1));
      return s;
   endfunction

   // Result monitor: sampled on the falling edge, ahead of the handshake edge.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         chk("result_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            exp_t e;
            logic [32:0] bound;
            e = sb.pop_front();
            bound = 33'(e.a) * 33'(e.b) + ((e.m == 2'b10) ? 33'd128 : 33'd0);
            chk("out_res", 64'(bus.out_res), 64'(e.res));
            chk("out_mode", 64'(bus.out_mode), 64'(e.mode));
            chk("approx_bound", 64'({1'b0, bus.out_res} <= bound), 64'd1);
         end
      end
   end

   // Random sink backpressure, active only during the random phase.
   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                        input bit expect_it, input logic [31:0] res, output int t0);
      int t;
      t = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_mode  = m;
      while (!bus.in_ready && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
      if (expect_it) sb.push_back('{a, b, m, res, (m == 2'b11) ? 2'b00 : m});
      @(posedge clk);
      #1;
      t0 = cyc;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int t0, input int lat, input string tag);
      int n;
      n = 0;
      while (!bus.out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(tag, 64'(cyc - t0), 64'(lat));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_scoreboard_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int t0, lat2, lat4;
      logic [31:0] r2, r4, hold;
      logic [15:0] ra, rb;
      logic [1:0]  rm;

      bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_mode = 0; bus.out_ready = 1;
      bus2.in_valid = 0; bus2.in_a = 0; bus2.in_b = 0; bus2.in_mode = 0; bus2.out_ready = 1;
      bus4.in_valid = 0; bus4.in_a = 0; bus4.in_b = 0; bus4.in_mode = 0; bus4.out_ready = 1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_out_res", 64'(bus.out_res), 64'd0);
      chk("reset_out_mode", 64'(bus.out_mode), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

      // BPC=2 and BPC=4: same truncated result, shorter latency
      chk("bpc2_in_ready", 64'(bus2.in_ready), 64'd1);
      chk("bpc4_in_ready", 64'(bus4.in_ready), 64'd1);
      bus2.in_valid = 1; bus2.in_a = 16'h0E01; bus2.in_b = 16'h0008; bus2.in_mode = 2'b01;
      bus4.in_valid = 1; bus4.in_a = 16'h0E01; bus4.in_b = 16'h0008; bus4.in_mode = 2'b01;
      @(posedge clk);
      #1;
      t0 = cyc;
      bus2.in_valid = 0;
      bus4.in_valid = 0;
      lat2 = -1; lat4 = -1; r2 = '0; r4 = '0;
      for (int i = 0; i < 40; i++) begin
         if (bus2.out_valid && lat2 < 0) begin lat2 = cyc - t0; r2 = bus2.out_res; end
         if (bus4.out_valid && lat4 < 0) begin lat4 = cyc - t0; r4 = bus4.out_res; end
         @(posedge clk);
         #1;
      end
      chk("bpc2_latency", 64'(lat2), 64'd8);
      chk("bpc4_latency", 64'(lat4), 64'd4);
      chk("bpc2_res", 64'(r2), 64'h7000);
      chk("bpc4_res", 64'(r4), 64'h7000);

      // Directed exact / truncated / compensated / reserved
      issue(16'hA0A0, 16'h0A0A, 2'b00, 1, 32'h064C8640, t0);
      wait_valid(t0, 16, "latency_exact");
      issue(16'hFFFF, 16'hFFFF, 2'b00, 1, 32'hFFFE0001, t0);
      wait_valid(t0, 16, "latency_allones");
      issue(16'h0004, 16'h0002, 2'b01, 1, 32'h00000000, t0);
      issue(16'h0004, 16'h0002, 2'b10, 1, 32'h00000080, t0);
      issue(16'h0004, 16'h0002, 2'b11, 1, 32'h00000008, t0);
      issue(16'h0E01, 16'h0008, 2'b01, 1, 32'h00007000, t0);
      issue(16'hFFFF, 16'hFFFF, 2'b10, 1, model(16'hFFFF, 16'hFFFF, 2'b10), t0);
      drain();

      // Backpressure: result frozen, no new acceptance
      bus.out_ready = 0;
      issue(16'h1234, 16'h5678, 2'b00, 1, 32'h06260060, t0);
      wait_valid(t0, 16, "latency_bp");
      hold = bus.out_res;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.in_a = 16'h00FF; bus.in_b = 16'h00FF; bus.in_mode = 2'b00;
         @(posedge clk);
         #1;
         chk("bp_out_res_stable", 64'(bus.out_res), 64'h06260060);
         chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      end
      chk("bp_hold_value", 64'(hold), 64'h06260060);
      bus.in_valid = 0;
      bus.out_ready = 1;
      drain();
      @(posedge clk);
      #1;
      chk("in_ready_after_handshake", 64'(bus.in_ready), 64'd1);

      // Reset while DONE is held by backpressure
      bus.out_ready = 0;
      issue(16'h0003, 16'h0003, 2'b10, 0, 32'h0, t0);
      wait_valid(t0, 16, "latency_pre_reset");
      rst_n = 0;
      #1;
      chk("rst_done_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_done_out_res", 64'(bus.out_res), 64'd0);
      chk("rst_done_out_mode", 64'(bus.out_mode), 64'd0);
      chk("rst_done_in_ready", 64'(bus.in_ready), 64'd0);
      #2 rst_n = 1;
      bus.out_ready = 1;
      @(posedge clk);
      #1;

      // Reset mid-BUSY
      issue(16'h00FF, 16'h00FF, 2'b00, 0, 32'h0, t0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      chk("rst_busy_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy_out_res", 64'(bus.out_res), 64'd0);
      chk("rst_busy_in_ready", 64'(bus.in_ready), 64'd0);
      #2 rst_n = 1;
      @(posedge clk);
      #1;
      issue(16'h0003, 16'h0005, 2'b00, 1, 32'd15, t0);
      wait_valid(t0, 16, "latency_after_reset");
      drain();

      // Random operations over all modes with random sink readiness
      rand_rdy = 1;
      for (int i = 0; i < 2000; i++) begin
         ra = (i % 8 == 0) ? 16'hFFFF : 16'($urandom);
         rb = (i % 8 == 1) ? 16'hFFFF : 16'($urandom);
         rm = 2'($urandom_range(0, 3));
         issue(ra, rb, rm, 1, model(ra, rb, rm), t0);
      end
      drain();
      rand_rdy = 0;
      bus.out_ready = 1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
